gain_cmd_sequencer: RTL

GAIN_CMD_SEQUENCER -- requirements
Module: gain_cmd_sequencer

---
 rtl/gain_cmd_sequencer_if.sv | 25 ++
 rtl/gain_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_cmd_sequencer_if.sv
// Byte-stream link between the UART and the gain command sequencer.
// The master side is the UART/host; the slave side is the sequencer.
interface gain_cmd_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/gain_cmd_sequencer.sv
// ASCII command sequencer for the PID gain registers: parses "K/I/D hhhh CR" writes,
// launches the auto-tuner on "T", and returns a one-byte 'O'/'E' response per command.
module gain_cmd_sequencer #(
    parameter logic [15:0] DEFAULT_KP  = 16'h0100,
    parameter logic [15:0] DEFAULT_KI  = 16'h0010,
    parameter logic [15:0] DEFAULT_KD  = 16'h0040,
    parameter int unsigned TIMEOUT_CYC = 120000
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    gain_cmd_sequencer_if.slave         uart,
    input  logic                        tuning_done,
    input  logic [15:0]                 kp_tune,
    input  logic [15:0]                 ki_tune,
    input  logic [15:0]                 kd_tune,
    output logic [15:0]                 kp_reg,
    output logic [15:0]                 ki_reg,
    output logic [15:0]                 kd_reg,
    output logic                        tune_start,
    output logic                        tune_busy,
    output logic                        resp_ovf
);

    localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYC + 2);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    localparam logic [7:0] CH_K     = 8'h4B;
    localparam logic [7:0] CH_I     = 8'h49;
    localparam logic [7:0] CH_D     = 8'h44;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] RESP_OK  = 8'h4F;
    localparam logic [7:0] RESP_ERR = 8'h45;

    localparam logic [1:0] TGT_K = 2'd0;
    localparam logic [1:0] TGT_I = 2'd1;
    localparam logic [1:0] TGT_D = 2'd2;

    localparam logic [47:0] GAIN_DEFAULTS = {DEFAULT_KD, DEFAULT_KI, DEFAULT_KP};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEX     = 2'd1,
        ST_WAIT_CR = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      digit_cnt_reg, digit_cnt_next;
    logic [1:0]      target_reg, target_next;
    logic [15:0]     acc_reg, acc_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            done_q_reg;

    logic            is_hex;
    logic [3:0]      nibble;
    logic            timed_out;
    logic            cmd_resp_valid;
    logic [7:0]      cmd_resp_byte;
    logic            t_accept;
    logic            gain_wr;
    logic            tune_load;

    logic [15:0]     gain_tune [3];
    logic [15:0]     gain_cur  [3];

    assign timed_out = (to_cnt_reg == TO_LIMIT);
    assign tune_load = tuning_done && !done_q_reg && tune_busy;

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (uart.rx_data >= 8'h30 && uart.rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = uart.rx_data[3:0];
        end else if ((uart.rx_data >= 8'h41 && uart.rx_data <= 8'h46) ||
                     (uart.rx_data >= 8'h61 && uart.rx_data <= 8'h66)) begin
            // 'A'/'a' carry 1 in the low nibble, so +9 maps them onto 10..15
            is_hex = 1'b1;
            nibble = uart.rx_data[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_next     = state_reg;
        digit_cnt_next = digit_cnt_reg;
        target_next    = target_reg;
        acc_next       = acc_reg;
        to_cnt_next    = to_cnt_reg;
        cmd_resp_valid = 1'b0;
        cmd_resp_byte  = 8'h00;
        t_accept       = 1'b0;
        gain_wr        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                to_cnt_next = '0;
                if (uart.rx_valid) begin
                    case (uart.rx_data)
                        CH_K, CH_I, CH_D: begin
                            target_next    = (uart.rx_data == CH_K) ? TGT_K :
                                             (uart.rx_data == CH_I) ? TGT_I : TGT_D;
                            digit_cnt_next = 2'd0;
                            acc_next       = 16'h0000;
                            state_next     = ST_HEX;
                        end
                        CH_T: begin
                            cmd_resp_valid = 1'b1;
                            cmd_resp_byte  = tune_busy ? RESP_ERR : RESP_OK;
                            t_accept       = !tune_busy;
                        end
                        CH_CR, CH_LF: ;
                        default: begin
                            cmd_resp_valid = 1'b1;
                            cmd_resp_byte  = RESP_ERR;
                        end
                    endcase
                end
            end

            ST_HEX: begin
                if (uart.rx_valid) begin
                    to_cnt_next = '0;
                    if (is_hex) begin
                        acc_next       = {acc_reg[11:0], nibble};
                        digit_cnt_next = digit_cnt_reg + 2'd1;
                        if (digit_cnt_reg == 2'd3) begin
                            state_next = ST_WAIT_CR;
                        end
                    end else begin
                        cmd_resp_valid = 1'b1;
                        cmd_resp_byte  = RESP_ERR;
                        state_next     = ST_IDLE;
                    end
                end else if (timed_out) begin
                    cmd_resp_valid = 1'b1;
                    cmd_resp_byte  = RESP_ERR;
                    to_cnt_next    = '0;
                    state_next     = ST_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end

            ST_WAIT_CR: begin
                if (uart.rx_valid) begin
                    to_cnt_next    = '0;
                    cmd_resp_valid = 1'b1;
                    state_next     = ST_IDLE;
                    // Manual writes are locked out while the tuner owns the gains
                    if (uart.rx_data == CH_CR && !tune_busy) begin
                        gain_wr       = 1'b1;
                        cmd_resp_byte = RESP_OK;
                    end else begin
                        cmd_resp_byte = RESP_ERR;
                    end
                end else if (timed_out) begin
                    cmd_resp_valid = 1'b1;
                    cmd_resp_byte  = RESP_ERR;
                    to_cnt_next    = '0;
                    state_next     = ST_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end

            default: begin
                state_next  = ST_IDLE;
                to_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            digit_cnt_reg <= 2'd0;
            target_reg    <= TGT_K;
            acc_reg       <= 16'h0000;
            to_cnt_reg    <= '0;
            done_q_reg    <= 1'b0;
            tune_start    <= 1'b0;
            tune_busy     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_cnt_reg <= digit_cnt_next;
            target_reg    <= target_next;
            acc_reg       <= acc_next;
            to_cnt_reg    <= to_cnt_next;
            done_q_reg    <= tuning_done;
            tune_start    <= t_accept;
            if (t_accept) begin
                tune_busy <= 1'b1;
            end else if (tune_load) begin
                tune_busy <= 1'b0;
            end
        end
    end

    assign gain_tune[0] = kp_tune;
    assign gain_tune[1] = ki_tune;
    assign gain_tune[2] = kd_tune;

    // One register per gain; tuner load and manual write are mutually exclusive via tune_busy
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_gain
            logic [15:0] gain_q;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    gain_q <= GAIN_DEFAULTS[gi*16 +: 16];
                end else if (tune_load) begin
                    gain_q <= gain_tune[gi];
                end else if (gain_wr && target_reg == 2'(gi)) begin
                    gain_q <= acc_reg;
                end
            end
            assign gain_cur[gi] = gain_q;
        end
    endgenerate

    assign kp_reg = gain_cur[0];
    assign ki_reg = gain_cur[1];
    assign kd_reg = gain_cur[2];

    // Single-entry response holding register; the tuner response wins a same-cycle collision
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            uart.tx_data  <= 8'h00;
            uart.tx_valid <= 1'b0;
            resp_ovf      <= 1'b0;
        end else if (tune_load) begin
            uart.tx_data  <= RESP_OK;
            uart.tx_valid <= 1'b1;
            if (cmd_resp_valid || (uart.tx_valid && !uart.tx_ready)) begin
                resp_ovf <= 1'b1;
            end
        end else if (cmd_resp_valid) begin
            uart.tx_data  <= cmd_resp_byte;
            uart.tx_valid <= 1'b1;
            if (uart.tx_valid && !uart.tx_ready) begin
                resp_ovf <= 1'b1;
            end
        end else if (uart.tx_valid && uart.tx_ready) begin
            uart.tx_valid <= 1'b0;
        end
    end

endmodule
